// File: rtl/reverse_sched.sv
// Two-channel round-robin front end sharing one bit-serial word reverser.
// A granted word shifts out LSB-first into the result register over WIDTH cycles.
module reverse_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    input  logic             resp_ready,
    output logic             busy
);

    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             last;
    logic             id;
    logic [WIDTH-1:0] in_sr;
    logic [WIDTH-1:0] out_sr;
    logic [CW-1:0]    cnt;
    logic             winner;
    logic             take;
    logic             cnt_end;

    assign cnt_end = (cnt == CW'(WIDTH - 1));

    // Under contention the channel not served last goes first.
    always_comb begin
        winner = req_valid[1];
        if (req_valid == 2'b11) begin
            winner = ~last;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && rst_n && (req_valid != 2'b00)) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign take = |req_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = SHIFT;
            SHIFT:   if (cnt_end) state_nx = DONE;
            DONE:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last   <= 1'b1;
            id     <= 1'b0;
            in_sr  <= '0;
            out_sr <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        in_sr  <= winner ? req_data1 : req_data0;
                        out_sr <= '0;
                        cnt    <= '0;
                        id     <= winner;
                    end
                end
                SHIFT: begin
                    out_sr <= {out_sr[WIDTH-2:0], in_sr[0]};
                    in_sr  <= in_sr >> 1;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    if (resp_ready) begin
                        last <= id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_valid = (state == DONE);
    assign resp_data  = out_sr;
    assign resp_id    = id;
    assign busy       = (state != IDLE);

endmodule
